// File: rtl/chan_mux_pkg.sv
// Shared constants and helpers for the channel multiplexer/scanner.
package chan_mux_pkg;

    // Operating modes presented on the mode input.
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : chan_mux_pkg

// File: rtl/chan_mux_ptr.sv
// Channel pointer: owns the current selection and the scan dwell counter.
// In MANUAL mode it follows a legal sel request with one cycle of latency.
// In SCAN mode it advances after every accept, or after DWELL consecutive
// idle cycles on an empty channel; a valid but stalled channel is held.
module chan_mux_ptr
    import chan_mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int DWELL = 4,
    localparam int SW    = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode_i,
    input  logic [SW-1:0] sel_i,
    input  logic          accept_i,
    input  logic          cur_valid_i,
    output logic [SW-1:0] cur_sel_o
);

    localparam int            DW         = sel_width(DWELL);
    localparam logic [SW-1:0] LAST_SEL   = SW'(N - 1);
    localparam logic [DW-1:0] LAST_DWELL = DW'(DWELL - 1);

    logic [SW-1:0] sel_q;
    logic [SW-1:0] sel_d;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_d;
    logic [SW-1:0] sel_inc;
    logic          sel_req_legal;

    // Wrapping successor of the current channel; never produces a value >= N.
    always_comb begin
        sel_inc = (sel_q == LAST_SEL) ? '0 : sel_q + SW'(1);
    end

    // A manual request outside 0..N-1 is ignored so the pointer holds.
    always_comb begin
        sel_req_legal = (int'(sel_i) < N);
    end

    // Next selection and dwell count for both modes.
    always_comb begin
        sel_d   = sel_q;
        dwell_d = dwell_q;
        if (mode_i == MODE_MANUAL) begin
            if (sel_req_legal) begin
                sel_d = sel_i;
            end
            dwell_d = '0;
        end else if (accept_i) begin
            sel_d   = sel_inc;
            dwell_d = '0;
        end else if (!cur_valid_i) begin
            if (dwell_q == LAST_DWELL) begin
                sel_d   = sel_inc;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
        // Valid channel without accept: hold both pointer and counter.
    end

    // Pointer state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q   <= '0;
            dwell_q <= '0;
        end else begin
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
        end
    end

    assign cur_sel_o = sel_q;

endmodule : chan_mux_ptr

// File: rtl/chan_mux_scan.sv
// N-channel to one multiplexer with a registered output stage.
// Only the selected channel sees in_ready; the pointer sub-module decides
// which channel that is, either manually or by round-robin scanning.
module chan_mux_scan
    import chan_mux_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int N     = 4,
    parameter  int DWELL = 4,
    localparam int SW    = sel_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  cur_sel
);

    logic [N-1:0] hit;
    logic [W-1:0] masked [N];
    logic [W-1:0] sel_data;
    logic         can_load;
    logic         cur_valid;
    logic         accept;

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         valid_q;
    logic         valid_d;

    // One-hot decode of the current channel and per-channel data gating.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign hit[gi]    = (cur_sel == SW'(gi));
            assign masked[gi] = in_data[gi*W +: W] & {W{hit[gi]}};
        end
    endgenerate

    // OR-reduce the gated channels: at most one is non-zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            sel_data = sel_data | masked[k];
        end
    end

    // Output register is free when empty or being drained this cycle.
    always_comb begin
        can_load  = !valid_q || out_ready;
        cur_valid = |(in_valid & hit);
        accept    = rst_n && can_load && cur_valid;
        in_ready  = (rst_n && can_load) ? hit : '0;
    end

    // Output stage next state: load on accept, otherwise drain or hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = sel_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register; reset discards any held word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

    chan_mux_ptr #(
        .N     (N),
        .DWELL (DWELL)
    ) u_ptr (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_i      (mode),
        .sel_i       (sel),
        .accept_i    (accept),
        .cur_valid_i (cur_valid),
        .cur_sel_o   (cur_sel)
    );

endmodule : chan_mux_scan

// File: tb/tb_chan_mux_scan.sv
// Scoreboard bench for chan_mux_scan (W=8, N=3, DWELL=4).
// The stimulus process runs a behavioural model of the channel pointer and
// output occupancy and queues every word it expects to be accepted; the
// monitor pops and compares whenever the DUT hands a word downstream.
module tb_chan_mux_scan;

    localparam int W     = 8;
    localparam int N     = 3;
    localparam int DWELL = 4;
    localparam int SW    = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  cur_sel;

    always #5 clk = ~clk;

    chan_mux_scan #(.W(W), .N(N), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cur_sel   (cur_sel)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q [$];

    // Reference model state
    int m_sel     = 0;   // channel the model believes is selected
    int m_idle    = 0;   // consecutive empty cycles seen on that channel
    bit m_full    = 0;   // output register holds an unconsumed word
    bit prev_rst  = 0;   // previous cycle had reset asserted

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive after the falling edge, then check the
    // presented state against the model and advance the model.
    task automatic cyc(input bit r, input bit md, input int s, input logic [N-1:0] v,
                       input bit ordy, input logic [N*W-1:0] d);
        logic [N-1:0] exp_rdy;
        bit           can_load;
        bit           acc;
        logic [W-1:0] word;
        @(negedge clk);
        rst_n     = r;
        mode      = md;
        sel       = SW'(s);
        in_valid  = v;
        out_ready = ordy;
        in_data   = d;
        #3;
        can_load = !m_full || ordy;
        exp_rdy  = '0;
        if (r && can_load) exp_rdy[m_sel] = 1'b1;
        check("cur_sel", 32'(cur_sel), 32'(m_sel));
        check("out_valid", 32'(out_valid), 32'(m_full));
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (prev_rst) check("out_data_after_reset", 32'(out_data), 32'h0);
        prev_rst = !r;
        if (!r) begin
            m_sel  = 0;
            m_idle = 0;
            m_full = 0;
            exp_q.delete();
            return;
        end
        acc = v[m_sel] && can_load;
        if (acc) begin
            word = d[m_sel*W +: W];
            exp_q.push_back(word);
        end
        m_full = acc ? 1'b1 : (ordy ? 1'b0 : m_full);
        if (md == 1'b0) begin
            if (s < N) m_sel = s;
            m_idle = 0;
        end else if (acc) begin
            m_sel  = (m_sel + 1) % N;
            m_idle = 0;
        end else if (!v[m_sel]) begin
            m_idle++;
            if (m_idle == DWELL) begin
                m_sel  = (m_sel + 1) % N;
                m_idle = 0;
            end
        end
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
        return d;
    endfunction

    // Monitor: compare the presented word whenever the DUT holds one, and
    // retire it when downstream takes it at the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_out: got %0h expected no word", out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) begin
                        $display("xfer data=%02h", out_data);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] d;
        rst_n = 0; mode = 0; sel = 0; in_valid = 0; out_ready = 0; in_data = '0;
        // Reset
        repeat (3) cyc(0, 0, 0, 3'b000, 1, rnd_data());
        // Manual path: select ch2 carrying 0xA5
        d = rnd_data(); d[2*W +: W] = 8'hA5;
        cyc(1, 0, 2, 3'b000, 1, d);
        cyc(1, 0, 2, 3'b111, 1, d);
        cyc(1, 0, 2, 3'b000, 1, d);
        // Back-pressure on ch1: two words offered while downstream stalls
        cyc(1, 0, 1, 3'b000, 0, rnd_data());
        d = '0; d[1*W +: W] = 8'h11;
        cyc(1, 0, 1, 3'b010, 0, d);
        d[1*W +: W] = 8'h22;
        repeat (3) cyc(1, 0, 1, 3'b010, 0, d);
        cyc(1, 0, 1, 3'b010, 1, d);
        cyc(1, 0, 1, 3'b000, 1, d);
        // Illegal select holds ch1
        repeat (3) cyc(1, 0, 3, 3'b000, 1, rnd_data());
        // Scan wrap with every channel valid
        cyc(1, 0, 0, 3'b000, 1, rnd_data());
        repeat (8) cyc(1, 1, 0, 3'b111, 1, rnd_data());
        // Dwell skip from idle ch0 to valid ch1, then stall ch1
        cyc(1, 0, 0, 3'b000, 1, rnd_data());
        repeat (6) cyc(1, 1, 0, 3'b010, 0, rnd_data());
        repeat (10) cyc(1, 1, 0, 3'b010, 0, rnd_data());
        cyc(1, 1, 0, 3'b010, 1, rnd_data());
        // Mode toggle in an accept cycle
        cyc(1, 0, 0, 3'b000, 1, rnd_data());
        cyc(1, 1, 1, 3'b001, 1, rnd_data());
        cyc(1, 0, 1, 3'b010, 1, rnd_data());
        cyc(1, 1, 0, 3'b010, 1, rnd_data());
        // Reset mid-operation while holding a word in SCAN
        cyc(1, 1, 0, 3'b111, 0, rnd_data());
        cyc(0, 1, 0, 3'b111, 0, rnd_data());
        cyc(1, 1, 0, 3'b000, 1, rnd_data());
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                (i % 200 < 120) ? 1'b1 : bit'($urandom_range(0, 1)),
                $urandom_range(0, 3),
                N'($urandom),
                bit'($urandom_range(0, 3) != 0),
                rnd_data());
        end
        // Drain and confirm nothing remains
        repeat (3) cyc(1, 0, 0, 3'b000, 1, rnd_data());
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_chan_mux_scan
